// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: read-side consumer for the async FIFO.
// Pops the FIFO read port (rinc/rempty/rdata) under a credit rule and
// re-presents the words as a valid/ready stream through a 3-entry
// prefetch buffer. Also offers a synchronous flush and a delivered-word count.
//
// Stream handshake: a word transfers on every rclk edge where m_valid and
// m_ready are both high. Once m_valid is high, m_valid and m_data hold
// until that transfer happens; only flush or reset may withdraw them.
// m_ready may change at any time and has no combinational path to rinc.
module afifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [1:0]            occ,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    // Buffer storage and bookkeeping; pointers count modulo 3.
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            occ_q;
    logic                  inflight;
    logic [CNT_WIDTH-1:0]  count_q;

    logic [2:0] committed;
    logic       wr_en;
    logic       pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit rule and buffer write/pop strobes. Words already requested
    // (inflight) count against the three slots, so a returning word always
    // finds room. rinc is held low during reset so no pop leaves early.
    always_comb begin
        committed = {1'b0, occ_q} + {2'b00, inflight};
        rinc      = rrst_n && !rempty && !flush && (committed < 3'd3);
        wr_en     = !flush && ((RD_LATENCY == 0) ? rinc : inflight);
        pop       = m_valid && m_ready && !flush;
    end

    // Stream outputs come straight from the buffer registers.
    always_comb begin
        m_valid  = (occ_q != 2'd0);
        m_data   = buf_q[rd_ptr];
        occ      = occ_q;
        rd_count = count_q;
    end

    // Buffer, pointers, occupancy and read-latency tracking.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            occ_q    <= 2'd0;
            inflight <= 1'b0;
        end else if (flush) begin
            // Drop buffered words and any word returning at this edge.
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            occ_q    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            if (wr_en) begin
                buf_q[wr_ptr] <= rdata;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
            // With zero read latency the word lands at the rinc edge,
            // so nothing is ever outstanding.
            inflight <= (RD_LATENCY != 0) && rinc;
        end
    end

    // Delivered-word counter; wraps freely and survives flush.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// tb_afifo_rd_stream: two instances share the stream controls; dut_a uses
// one-cycle read latency with a 16-bit count, dut_b zero read latency with
// a 4-bit count. Each has its own FIFO source model feeding rempty/rdata.
module tb_afifo_rd_stream;
    localparam int DW = 32;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          m_ready;
    logic          flush;
    logic          hold_empty;
    logic          rempty_a, rempty_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          rinc_a, rinc_b;
    logic          m_valid_a, m_valid_b;
    logic [DW-1:0] m_data_a, m_data_b;
    logic [1:0]    occ_a, occ_b;
    logic [15:0]   cnt_a;
    logic [3:0]    cnt_b;

    logic [DW-1:0] src_a[$];
    logic [DW-1:0] src_b[$];
    logic [DW-1:0] got_a[$];
    logic [DW-1:0] got_b[$];
    logic [DW-1:0] exp_q[$];
    logic [15:0]   exp_cnt;
    int            viol_a, viol_b;
    int            n_pass, n_total;
    logic          stall_a, stall_b;
    logic [DW-1:0] hold_a, hold_b;

    afifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(1), .CNT_WIDTH(16)) dut_a (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty_a), .rdata(rdata_a),
        .rinc(rinc_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
        .flush(flush), .occ(occ_a), .rd_count(cnt_a)
    );

    afifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(0), .CNT_WIDTH(4)) dut_b (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty_b), .rdata(rdata_b),
        .rinc(rinc_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
        .flush(flush), .occ(occ_b), .rd_count(cnt_b)
    );

    // Clock
    always #5 rclk = ~rclk;

    // One clock cycle: observe the streams at the falling edge, then advance
    // both FIFO source models just after the rising edge. Returns 2 time
    // units after the rising edge, when outputs have settled.
    task automatic tick();
        logic ra, rb;
        @(negedge rclk);
        ra = rinc_a;
        rb = rinc_b;
        if (!rrst_n) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            if (rinc_a && rempty_a) viol_a++;
            if (m_valid_a !== (occ_a != 2'd0)) viol_a++;
            if (stall_a && (m_valid_a !== 1'b1 || m_data_a !== hold_a)) viol_a++;
            if (m_valid_a && m_ready && !flush) got_a.push_back(m_data_a);
            stall_a = m_valid_a && !m_ready && !flush;
            hold_a  = m_data_a;
            if (rinc_b && rempty_b) viol_b++;
            if (m_valid_b !== (occ_b != 2'd0)) viol_b++;
            if (stall_b && (m_valid_b !== 1'b1 || m_data_b !== hold_b)) viol_b++;
            if (m_valid_b && m_ready && !flush) got_b.push_back(m_data_b);
            stall_b = m_valid_b && !m_ready && !flush;
            hold_b  = m_data_b;
        end
        @(posedge rclk);
        #1;
        // Latency 1: the popped word appears on rdata the cycle after rinc.
        if (ra && src_a.size() != 0) rdata_a = src_a.pop_front();
        else rdata_a = $urandom;
        // Latency 0: rdata always shows the current head.
        if (rb && src_b.size() != 0) void'(src_b.pop_front());
        rdata_b  = (src_b.size() != 0) ? src_b[0] : $urandom;
        rempty_a = hold_empty || (src_a.size() == 0);
        rempty_b = hold_empty || (src_b.size() == 0);
        #1;
    endtask

    task automatic push_words(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            src_a.push_back(w);
            src_b.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    // Number of differences between the delivered words since 'base' and exp_q.
    function automatic int seq_errs_a(input int base);
        int e = 0;
        if (got_a.size() - base != exp_q.size()) e++;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= got_a.size() || got_a[base+i] !== exp_q[i]) e++;
        return e;
    endfunction

    function automatic int seq_errs_b(input int base);
        int e = 0;
        if (got_b.size() - base != exp_q.size()) e++;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= got_b.size() || got_b[base+i] !== exp_q[i]) e++;
        return e;
    endfunction

    task automatic test_reset();
        rrst_n = 1'b0;
        exp_q.delete();
        push_words(3);
        tick();
        tick();
        n_total++; if (rinc_a !== 1'b0) $display("FAIL reset_rinc_a: got %b want 0", rinc_a); else n_pass++;
        n_total++; if (rinc_b !== 1'b0) $display("FAIL reset_rinc_b: got %b want 0", rinc_b); else n_pass++;
        n_total++; if (m_valid_a !== 1'b0) $display("FAIL reset_valid_a: got %b want 0", m_valid_a); else n_pass++;
        n_total++; if (m_valid_b !== 1'b0) $display("FAIL reset_valid_b: got %b want 0", m_valid_b); else n_pass++;
        n_total++; if (m_data_a !== '0) $display("FAIL reset_data_a: got %h want 0", m_data_a); else n_pass++;
        n_total++; if (m_data_b !== '0) $display("FAIL reset_data_b: got %h want 0", m_data_b); else n_pass++;
        n_total++; if (occ_a !== 2'd0) $display("FAIL reset_occ_a: got %0d want 0", occ_a); else n_pass++;
        n_total++; if (occ_b !== 2'd0) $display("FAIL reset_occ_b: got %0d want 0", occ_b); else n_pass++;
        n_total++; if (cnt_a !== 16'd0) $display("FAIL reset_cnt_a: got %0d want 0", cnt_a); else n_pass++;
        n_total++; if (cnt_b !== 4'd0) $display("FAIL reset_cnt_b: got %0d want 0", cnt_b); else n_pass++;
        src_a.delete();
        src_b.delete();
        tick();
        rrst_n  = 1'b1;
        exp_cnt = '0;
        tick();
    endtask

    task automatic test_first_word();
        int base_a = got_a.size();
        int base_b = got_b.size();
        int tr_a = -1, tr_b = -1, tv_a = -1, tv_b = -1, lv_a = -1, lv_b = -1;
        int nr_a = 0, nr_b = 0, nv_a = 0, nv_b = 0;
        exp_q.delete();
        m_ready = 1'b1;
        push_words(5);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rinc_a) begin if (tr_a < 0) tr_a = c; nr_a++; end
            if (rinc_b) begin if (tr_b < 0) tr_b = c; nr_b++; end
            if (m_valid_a) begin if (tv_a < 0) tv_a = c; lv_a = c; nv_a++; end
            if (m_valid_b) begin if (tv_b < 0) tv_b = c; lv_b = c; nv_b++; end
        end
        n_total++; if (tv_a - tr_a !== 2) $display("FAIL first_lat_a: got %0d cycles want 2", tv_a - tr_a); else n_pass++;
        n_total++; if (tv_b - tr_b !== 1) $display("FAIL first_lat_b: got %0d cycles want 1", tv_b - tr_b); else n_pass++;
        n_total++; if (nr_a !== 5) $display("FAIL first_rinc_a: got %0d pops want 5", nr_a); else n_pass++;
        n_total++; if (nr_b !== 5) $display("FAIL first_rinc_b: got %0d pops want 5", nr_b); else n_pass++;
        n_total++; if (nv_a !== 5 || lv_a - tv_a !== 4) $display("FAIL first_run_a: got %0d valid over %0d cycles want 5 over 5", nv_a, lv_a - tv_a + 1); else n_pass++;
        n_total++; if (nv_b !== 5 || lv_b - tv_b !== 4) $display("FAIL first_run_b: got %0d valid over %0d cycles want 5 over 5", nv_b, lv_b - tv_b + 1); else n_pass++;
        n_total++; if (seq_errs_a(base_a) !== 0) $display("FAIL first_seq_a: got %0d word errors want 0", seq_errs_a(base_a)); else n_pass++;
        n_total++; if (seq_errs_b(base_b) !== 0) $display("FAIL first_seq_b: got %0d word errors want 0", seq_errs_b(base_b)); else n_pass++;
        exp_cnt = exp_cnt + 16'd5;
        n_total++; if (cnt_a !== exp_cnt) $display("FAIL first_cnt_a: got %0d want %0d", cnt_a, exp_cnt); else n_pass++;
        n_total++; if (cnt_b !== exp_cnt[3:0]) $display("FAIL first_cnt_b: got %0d want %0d", cnt_b, exp_cnt[3:0]); else n_pass++;
    endtask

    task automatic test_backpressure();
        int base_a = got_a.size();
        int base_b = got_b.size();
        int va = viol_a, vb = viol_b;
        int nr_a = 0, nr_b = 0, nv_a = 0, nv_b = 0;
        exp_q.delete();
        m_ready = 1'b0;
        push_words(10);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rinc_a) nr_a++;
            if (rinc_b) nr_b++;
        end
        n_total++; if (nr_a !== 3) $display("FAIL bp_pops_a: got %0d want 3", nr_a); else n_pass++;
        n_total++; if (nr_b !== 3) $display("FAIL bp_pops_b: got %0d want 3", nr_b); else n_pass++;
        n_total++; if (occ_a !== 2'd3 || rinc_a !== 1'b0) $display("FAIL bp_full_a: got occ %0d rinc %b want 3 0", occ_a, rinc_a); else n_pass++;
        n_total++; if (occ_b !== 2'd3 || rinc_b !== 1'b0) $display("FAIL bp_full_b: got occ %0d rinc %b want 3 0", occ_b, rinc_b); else n_pass++;
        n_total++; if (m_valid_a !== 1'b1 || m_data_a !== exp_q[0]) $display("FAIL bp_head_a: got %b %h want 1 %h", m_valid_a, m_data_a, exp_q[0]); else n_pass++;
        n_total++; if (m_valid_b !== 1'b1 || m_data_b !== exp_q[0]) $display("FAIL bp_head_b: got %b %h want 1 %h", m_valid_b, m_data_b, exp_q[0]); else n_pass++;
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (m_valid_a) nv_a++;
            if (m_valid_b) nv_b++;
            tick();
        end
        repeat (4) tick();
        n_total++; if (nv_a !== 10) $display("FAIL bp_stream_a: got %0d valid cycles of 10 want 10", nv_a); else n_pass++;
        n_total++; if (nv_b !== 10) $display("FAIL bp_stream_b: got %0d valid cycles of 10 want 10", nv_b); else n_pass++;
        n_total++; if (seq_errs_a(base_a) !== 0) $display("FAIL bp_seq_a: got %0d word errors want 0", seq_errs_a(base_a)); else n_pass++;
        n_total++; if (seq_errs_b(base_b) !== 0) $display("FAIL bp_seq_b: got %0d word errors want 0", seq_errs_b(base_b)); else n_pass++;
        n_total++; if (viol_a - va !== 0) $display("FAIL bp_stable_a: got %0d protocol errors want 0", viol_a - va); else n_pass++;
        n_total++; if (viol_b - vb !== 0) $display("FAIL bp_stable_b: got %0d protocol errors want 0", viol_b - vb); else n_pass++;
        exp_cnt = exp_cnt + 16'd10;
        n_total++; if (cnt_a !== exp_cnt) $display("FAIL bp_cnt_a: got %0d want %0d", cnt_a, exp_cnt); else n_pass++;
        n_total++; if (cnt_b !== exp_cnt[3:0]) $display("FAIL bp_cnt_b: got %0d want %0d", cnt_b, exp_cnt[3:0]); else n_pass++;
    endtask

    task automatic test_empty_toggle();
        int base_a = got_a.size();
        int base_b = got_b.size();
        int va = viol_a, vb = viol_b;
        exp_q.delete();
        m_ready = 1'b1;
        push_words(12);
        for (int c = 0; c < 60; c++) begin
            hold_empty = ~hold_empty;
            tick();
        end
        hold_empty = 1'b0;
        repeat (10) tick();
        n_total++; if (viol_a - va !== 0) $display("FAIL toggle_proto_a: got %0d protocol errors want 0", viol_a - va); else n_pass++;
        n_total++; if (viol_b - vb !== 0) $display("FAIL toggle_proto_b: got %0d protocol errors want 0", viol_b - vb); else n_pass++;
        n_total++; if (seq_errs_a(base_a) !== 0) $display("FAIL toggle_seq_a: got %0d word errors want 0", seq_errs_a(base_a)); else n_pass++;
        n_total++; if (seq_errs_b(base_b) !== 0) $display("FAIL toggle_seq_b: got %0d word errors want 0", seq_errs_b(base_b)); else n_pass++;
        exp_cnt = exp_cnt + 16'd12;
        n_total++; if (cnt_a !== exp_cnt) $display("FAIL toggle_cnt_a: got %0d want %0d", cnt_a, exp_cnt); else n_pass++;
        n_total++; if (cnt_b !== exp_cnt[3:0]) $display("FAIL toggle_cnt_b: got %0d want %0d", cnt_b, exp_cnt[3:0]); else n_pass++;
    endtask

    task automatic test_flush();
        int base_a, base_b;
        int waited = 0;
        logic [15:0] cnt_before;
        exp_q.delete();
        m_ready = 1'b0;
        push_words(6);
        while (occ_a != 2'd2 && waited < 10) begin
            tick();
            waited++;
        end
        n_total++; if (occ_a !== 2'd2) $display("FAIL flush_setup: got occ %0d want 2", occ_a); else n_pass++;
        // Two words buffered plus one in flight in dut_a; three buffered in dut_b.
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        cnt_before = cnt_a;
        base_a     = got_a.size();
        base_b     = got_b.size();
        flush      = 1'b1;
        m_ready    = 1'b1;
        #1;
        n_total++; if (rinc_a !== 1'b0) $display("FAIL flush_rinc_a: got %b want 0", rinc_a); else n_pass++;
        n_total++; if (rinc_b !== 1'b0) $display("FAIL flush_rinc_b: got %b want 0", rinc_b); else n_pass++;
        tick();
        flush = 1'b0;
        n_total++; if (occ_a !== 2'd0 || m_valid_a !== 1'b0) $display("FAIL flush_clear_a: got occ %0d valid %b want 0 0", occ_a, m_valid_a); else n_pass++;
        n_total++; if (occ_b !== 2'd0 || m_valid_b !== 1'b0) $display("FAIL flush_clear_b: got occ %0d valid %b want 0 0", occ_b, m_valid_b); else n_pass++;
        n_total++; if (cnt_a !== cnt_before) $display("FAIL flush_cnt_hold: got %0d want %0d", cnt_a, cnt_before); else n_pass++;
        repeat (10) tick();
        n_total++; if (seq_errs_a(base_a) !== 0) $display("FAIL flush_seq_a: got %0d word errors want 0", seq_errs_a(base_a)); else n_pass++;
        n_total++; if (seq_errs_b(base_b) !== 0) $display("FAIL flush_seq_b: got %0d word errors want 0", seq_errs_b(base_b)); else n_pass++;
        exp_cnt = exp_cnt + 16'd3;
        n_total++; if (cnt_a !== exp_cnt) $display("FAIL flush_cnt_a: got %0d want %0d", cnt_a, exp_cnt); else n_pass++;
        n_total++; if (cnt_b !== exp_cnt[3:0]) $display("FAIL flush_cnt_b: got %0d want %0d", cnt_b, exp_cnt[3:0]); else n_pass++;
    endtask

    task automatic test_wrap();
        int base_a, base_b;
        rrst_n = 1'b0;
        tick();
        rrst_n  = 1'b1;
        exp_cnt = '0;
        tick();
        base_a = got_a.size();
        base_b = got_b.size();
        exp_q.delete();
        m_ready = 1'b1;
        push_words(17);
        repeat (30) tick();
        exp_cnt = exp_cnt + 16'd17;
        n_total++; if (cnt_b !== exp_cnt[3:0]) $display("FAIL wrap_cnt_b: got %0d want %0d", cnt_b, exp_cnt[3:0]); else n_pass++;
        n_total++; if (cnt_a !== exp_cnt) $display("FAIL wrap_cnt_a: got %0d want %0d", cnt_a, exp_cnt); else n_pass++;
        n_total++; if (seq_errs_b(base_b) !== 0) $display("FAIL wrap_seq_b: got %0d word errors want 0", seq_errs_b(base_b)); else n_pass++;
        n_total++; if (seq_errs_a(base_a) !== 0) $display("FAIL wrap_seq_a: got %0d word errors want 0", seq_errs_a(base_a)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base_a, base_b;
        int waited = 0;
        exp_q.delete();
        m_ready = 1'b0;
        push_words(10);
        while (occ_a != 2'd2 && waited < 10) begin
            tick();
            waited++;
        end
        n_total++; if (occ_a !== 2'd2) $display("FAIL rstmid_setup: got occ %0d want 2", occ_a); else n_pass++;
        #2;
        rrst_n = 1'b0;
        #1;
        n_total++; if (rinc_a !== 1'b0 || rinc_b !== 1'b0) $display("FAIL rstmid_rinc: got %b %b want 0 0", rinc_a, rinc_b); else n_pass++;
        n_total++; if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0) $display("FAIL rstmid_valid: got %b %b want 0 0", m_valid_a, m_valid_b); else n_pass++;
        n_total++; if (m_data_a !== '0 || m_data_b !== '0) $display("FAIL rstmid_data: got %h %h want 0 0", m_data_a, m_data_b); else n_pass++;
        n_total++; if (occ_a !== 2'd0 || occ_b !== 2'd0) $display("FAIL rstmid_occ: got %0d %0d want 0 0", occ_a, occ_b); else n_pass++;
        n_total++; if (cnt_a !== 16'd0 || cnt_b !== 4'd0) $display("FAIL rstmid_cnt: got %0d %0d want 0 0", cnt_a, cnt_b); else n_pass++;
        // The FIFO is reset alongside the consumer.
        src_a.delete();
        src_b.delete();
        tick();
        tick();
        rrst_n  = 1'b1;
        exp_cnt = '0;
        base_a  = got_a.size();
        base_b  = got_b.size();
        exp_q.delete();
        m_ready = 1'b1;
        push_words(4);
        repeat (15) tick();
        n_total++; if (seq_errs_a(base_a) !== 0) $display("FAIL rstmid_seq_a: got %0d word errors want 0", seq_errs_a(base_a)); else n_pass++;
        n_total++; if (seq_errs_b(base_b) !== 0) $display("FAIL rstmid_seq_b: got %0d word errors want 0", seq_errs_b(base_b)); else n_pass++;
        exp_cnt = exp_cnt + 16'd4;
        n_total++; if (cnt_a !== exp_cnt) $display("FAIL rstmid_cnt_a: got %0d want %0d", cnt_a, exp_cnt); else n_pass++;
    endtask

    task automatic test_random();
        int base_a = got_a.size();
        int base_b = got_b.size();
        int va = viol_a, vb = viol_b;
        int quiet = 0;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            m_ready    = ($urandom_range(0, 2) != 0);
            hold_empty = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) push_words(1);
            tick();
        end
        m_ready    = 1'b1;
        hold_empty = 1'b0;
        for (int k = 0; k < 400 && quiet < 4; k++) begin
            tick();
            if (src_a.size() == 0 && src_b.size() == 0 && occ_a == 2'd0 && occ_b == 2'd0) quiet++;
            else quiet = 0;
        end
        n_total++; if (quiet < 4) $display("FAIL rand_drain: got %0d quiet cycles want 4", quiet); else n_pass++;
        n_total++; if (seq_errs_a(base_a) !== 0) $display("FAIL rand_seq_a: got %0d word errors want 0", seq_errs_a(base_a)); else n_pass++;
        n_total++; if (seq_errs_b(base_b) !== 0) $display("FAIL rand_seq_b: got %0d word errors want 0", seq_errs_b(base_b)); else n_pass++;
        n_total++; if (viol_a - va !== 0) $display("FAIL rand_proto_a: got %0d protocol errors want 0", viol_a - va); else n_pass++;
        n_total++; if (viol_b - vb !== 0) $display("FAIL rand_proto_b: got %0d protocol errors want 0", viol_b - vb); else n_pass++;
        exp_cnt = exp_cnt + 16'(exp_q.size());
        n_total++; if (cnt_a !== exp_cnt) $display("FAIL rand_cnt_a: got %0d want %0d", cnt_a, exp_cnt); else n_pass++;
        n_total++; if (cnt_b !== exp_cnt[3:0]) $display("FAIL rand_cnt_b: got %0d want %0d", cnt_b, exp_cnt[3:0]); else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        viol_a     = 0;
        viol_b     = 0;
        exp_cnt    = '0;
        stall_a    = 1'b0;
        stall_b    = 1'b0;
        hold_a     = '0;
        hold_b     = '0;
        rrst_n     = 1'b0;
        m_ready    = 1'b0;
        flush      = 1'b0;
        hold_empty = 1'b0;
        rempty_a   = 1'b1;
        rempty_b   = 1'b1;
        rdata_a    = '0;
        rdata_b    = '0;

        test_reset();
        test_first_word();
        test_backpressure();
        test_empty_toggle();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
